// File: rtl/nios_debug_ocimem_sequencer.sv
// OCI debug memory sequencer: turns JTAG debug-slave strobes into single-word
// Avalon reads/writes with address auto-increment and a waitrequest timeout.
module nios_debug_ocimem_sequencer #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_read;
    logic               r_write;
    logic [31:0]        r_wdata;
    logic [31:0]        r_mon;
    logic               r_ready;
    logic               r_error;
    logic               r_busy;
    logic               r_inc;
    logic               r_ack_pend;
    logic [CNT_W-1:0]   r_cnt;

    logic w_any_strobe;
    logic w_timeout;
    logic w_unused_jdo;

    assign w_any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign w_timeout    = (TIMEOUT_CYCLES > 0) && mem_waitrequest && (r_cnt == CNT_LAST);
    assign w_unused_jdo = ^{jdo[37:35], jdo[2:0]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_mon      <= '0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b0;
            r_inc      <= 1'b0;
            r_ack_pend <= 1'b0;
            r_cnt      <= '0;
        end else begin
            // Address-only load acknowledges one cycle later; a new command overrides it.
            r_ack_pend <= 1'b0;
            if (r_ack_pend)
                r_ready <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (take_action_ocimem_b) begin
                        r_wdata <= jdo[34:3];
                        r_write <= 1'b1;
                        r_inc   <= 1'b1;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_WR;
                    end else if (take_action_ocimem_a) begin
                        r_addr  <= jdo[17 +: ADDR_W];
                        r_ready <= 1'b0;
                        r_error <= 1'b0;
                        if (jdo[34]) begin
                            r_read  <= 1'b1;
                            r_inc   <= 1'b0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_RD;
                        end else begin
                            r_ack_pend <= 1'b1;
                        end
                    end else if (take_no_action_ocimem_a) begin
                        r_read  <= 1'b1;
                        r_inc   <= 1'b1;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RD;
                    end
                end

                S_RD, S_WR: begin
                    // Commands arriving mid-access are dropped but flagged.
                    if (w_any_strobe)
                        r_error <= 1'b1;

                    if (!mem_waitrequest) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        if (r_state == S_RD)
                            r_mon <= mem_readdata;
                        if (r_inc)
                            r_addr <= r_addr + 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_error <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_address   = r_addr;
    assign mem_read      = r_read;
    assign mem_write     = r_write;
    assign mem_writedata = r_wdata;
    assign MonDReg       = r_mon;
    assign monitor_ready = r_ready;
    assign monitor_error = r_error;
    assign busy          = r_busy;

endmodule
